// File: rtl/ledm_pkg.sv
// Shared definitions for the LED scan controller: FSM encoding,
// default sizing parameters and the frame length helper.
package ledm_pkg;

    localparam int CH_NUM_DEF     = 8;
    localparam int MS_DIV_DEF     = 100000;
    localparam int REFRESH_MS_DEF = 10;
    localparam int SCLK_DIV_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LATCH    = 3'd4
    } scan_state_t;

    // One LOAD cycle, a low and a high half-period per bit, then the latch pulse.
    function automatic int frame_cycles(input int ch_num, input int sclk_div);
        return 1 + 4 * ch_num * sclk_div + sclk_div;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond strobe generator: free-running divider that raises
// clk_ms_en for one clk_sys cycle out of every MS_DIV.
module ms_tick_gen
    import ledm_pkg::*;
#(
    parameter int MS_DIV = MS_DIV_DEF
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    output logic clk_ms_en
);

    localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

    // A divider of one would hold the strobe high through reset.
    if (MS_DIV < 2) begin : g_bad_ms_div
        $error("ms_tick_gen: MS_DIV must be at least 2");
    end

    logic [CW-1:0] count;

    // Count 0..MS_DIV-1 and wrap back to zero after the terminal count.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign clk_ms_en = (count == LAST);

endmodule

// File: rtl/led_scan_ctl.sv
// LED scan controller: collects refresh and lamp-test requests into a
// single pending flag and shifts a frozen LED snapshot out MSB first to
// an external shift-register chain, finishing each frame with a latch pulse.
module led_scan_ctl
    import ledm_pkg::*;
#(
    parameter int CH_NUM     = CH_NUM_DEF,
    parameter int MS_DIV     = MS_DIV_DEF,
    parameter int REFRESH_MS = REFRESH_MS_DEF,
    parameter int SCLK_DIV   = SCLK_DIV_DEF
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic [2*CH_NUM-1:0]   led_in,
    input  logic                  led_en,
    input  logic                  lamp_test,
    output logic                  clk_ms_en,
    output logic                  led_sclk,
    output logic                  led_sdat,
    output logic                  led_latch,
    output logic                  scan_busy
);

    localparam int NBITS = 2 * CH_NUM;
    localparam int RW    = (REFRESH_MS > 1) ? $clog2(REFRESH_MS) : 1;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int DW    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_MS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_INIT = BW'(NBITS);

    // A frame must finish before the next periodic refresh is due.
    if (frame_cycles(CH_NUM, SCLK_DIV) >= REFRESH_MS * MS_DIV) begin : g_frame_too_long
        $error("led_scan_ctl: frame length must be shorter than the refresh period");
    end

    ms_tick_gen #(
        .MS_DIV(MS_DIV)
    ) u_ms_tick_gen (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .clk_ms_en (clk_ms_en)
    );

    logic [RW-1:0]    ref_cnt;
    logic             lamp_q;
    logic             pending;
    logic             refresh_req;
    logic             lamp_rise;
    logic [NBITS-1:0] frame_data;
    logic [NBITS-1:0] snap;
    logic [BW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;
    scan_state_t      state;

    assign refresh_req = clk_ms_en && (ref_cnt == REF_LAST);
    assign lamp_rise   = lamp_test && !lamp_q;
    assign frame_data  = lamp_test ? '1 : (led_en ? led_in : '0);

    // Count millisecond strobes towards the next refresh and keep a delayed lamp_test copy.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            ref_cnt <= '0;
            lamp_q  <= 1'b0;
        end else begin
            lamp_q <= lamp_test;
            if (clk_ms_en) begin
                ref_cnt <= (ref_cnt == REF_LAST) ? '0 : ref_cnt + RW'(1);
            end
        end
    end

    // Frame sequencer: pending flag, snapshot shifter and registered serial outputs.
    // A request arriving in the same cycle as IDLE->LOAD is served by that frame,
    // because the snapshot is taken one cycle later in LOAD.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state     <= IDLE;
            pending   <= 1'b0;
            snap      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            led_sclk  <= 1'b0;
            led_sdat  <= 1'b0;
            led_latch <= 1'b0;
            scan_busy <= 1'b0;
        end else begin
            pending <= pending || refresh_req || lamp_rise;
            case (state)
                IDLE: begin
                    if (pending) begin
                        state     <= LOAD;
                        pending   <= 1'b0;
                        scan_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    snap     <= frame_data;
                    led_sdat <= frame_data[NBITS-1];
                    bit_cnt  <= BIT_INIT;
                    div_cnt  <= '0;
                    state    <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        led_sclk <= 1'b1;
                        state    <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        led_sclk <= 1'b0;
                        snap     <= {snap[NBITS-2:0], 1'b0};
                        bit_cnt  <= bit_cnt - BW'(1);
                        if (bit_cnt == BW'(1)) begin
                            led_sdat  <= 1'b0;
                            led_latch <= 1'b1;
                            state     <= LATCH;
                        end else begin
                            led_sdat <= snap[NBITS-2];
                            state    <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt   <= '0;
                        led_latch <= 1'b0;
                        scan_busy <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_ctl.sv
// Self-checking bench for led_scan_ctl at CH_NUM=2, MS_DIV=10,
// REFRESH_MS=2, SCLK_DIV=2. Expected frame contents are queued when the
// inputs are driven and compared when the DUT finishes each frame.
module tb_led_scan_ctl;

    localparam int NB        = 4;
    localparam int FRAME_LEN = 19;
    localparam int LATCH_LEN = 2;
    localparam int NVEC      = 7;

    logic          clk_sys   = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic [NB-1:0] led_in    = '0;
    logic          led_en    = 1'b0;
    logic          lamp_test = 1'b0;
    logic          clk_ms_en;
    logic          led_sclk;
    logic          led_sdat;
    logic          led_latch;
    logic          scan_busy;

    int errors      = 0;
    int checks      = 0;
    int frames_done = 0;

    logic [NB-1:0] exp_q[$];

    typedef struct {
        logic [NB-1:0] led_in;
        logic          led_en;
        logic          lamp;
        logic [NB-1:0] exp_bits;
    } vec_t;

    vec_t vecs[NVEC];

    led_scan_ctl #(
        .CH_NUM     (2),
        .MS_DIV     (10),
        .REFRESH_MS (2),
        .SCLK_DIV   (2)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .led_in    (led_in),
        .led_en    (led_en),
        .lamp_test (lamp_test),
        .clk_ms_en (clk_ms_en),
        .led_sclk  (led_sclk),
        .led_sdat  (led_sdat),
        .led_latch (led_latch),
        .scan_busy (scan_busy)
    );

    // 100 MHz system clock.
    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NB-1:0] li, input logic en, input logic lt);
        led_in    = li;
        led_en    = en;
        lamp_test = lt;
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, "_clk_ms_en"}, clk_ms_en, 0);
        checkOutput({tag, "_led_sclk"},  led_sclk,  0);
        checkOutput({tag, "_led_sdat"},  led_sdat,  0);
        checkOutput({tag, "_led_latch"}, led_latch, 0);
        checkOutput({tag, "_scan_busy"}, scan_busy, 0);
    endtask

    // After release: strobe on every 10th edge, first LOAD on edge 21.
    task automatic startupCheck(input string tag);
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            checkOutput($sformatf("%s_ms_strobe_k%0d", tag, k), clk_ms_en, (k % 10 == 9) ? 1 : 0);
            checkOutput($sformatf("%s_busy_k%0d", tag, k), scan_busy, (k >= 21) ? 1 : 0);
        end
    endtask

    task automatic waitFrameEnd(input string tag);
        int start;
        start = frames_done;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            #1;
            if (frames_done != start) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s_frame_timeout: got no frame end, expected one within 100 cycles", tag);
    endtask

    task automatic waitBusyRise(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            #1;
            if (scan_busy) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s_busy_timeout: got scan_busy=0, expected 1 within 100 cycles", tag);
    endtask

    task automatic waitSclkRises(input string tag, input int n);
        int   seen;
        logic prev;
        seen = 0;
        prev = led_sclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            #1;
            if (led_sclk && !prev) seen++;
            prev = led_sclk;
            if (seen == n) return;
        end
        checks++;
        errors++;
        $display("[TB] FAIL %s_sclk_timeout: got %0d rises, expected %0d", tag, seen, n);
    endtask

    // Frame monitor: decodes serial bits on each led_sclk rise and scores each completed frame.
    initial begin : monitor
        logic [NB-1:0] bits;
        logic [NB-1:0] exp;
        int            nbits;
        int            busy_len;
        int            latch_len;
        logic          prev_sclk;
        logic          prev_busy;
        logic          prev_sdat;
        bits = '0; nbits = 0; busy_len = 0; latch_len = 0;
        prev_sclk = 1'b0; prev_busy = 1'b0; prev_sdat = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!rst_sys_n) begin
                bits = '0; nbits = 0; busy_len = 0; latch_len = 0;
                prev_sclk = 1'b0; prev_busy = 1'b0; prev_sdat = 1'b0;
            end else begin
                if (led_sdat !== prev_sdat) begin
                    checkOutput("sdat_change_sclk_low", led_sclk, 0);
                end
                if (led_sclk && !prev_sclk) begin
                    bits = {bits[NB-2:0], led_sdat};
                    nbits++;
                end
                if (scan_busy) busy_len++;
                if (led_latch) latch_len++;
                if (prev_busy && !scan_busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_frame: got frame %b, expected no frame", bits);
                    end else begin
                        exp = exp_q.pop_front();
                        checkOutput("frame_bits", bits, exp);
                    end
                    checkOutput("frame_sclk_rises", nbits, NB);
                    checkOutput("frame_busy_cycles", busy_len, FRAME_LEN);
                    checkOutput("frame_latch_cycles", latch_len, LATCH_LEN);
                    bits = '0; nbits = 0; busy_len = 0; latch_len = 0;
                    frames_done++;
                end
                prev_sclk = led_sclk;
                prev_busy = scan_busy;
                prev_sdat = led_sdat;
            end
        end
    end

    // Hard time limit so a stuck DUT can never hang the run.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 50000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        vecs[0] = '{4'b1001, 1'b1, 1'b0, 4'b1001};
        vecs[1] = '{4'b1111, 1'b0, 1'b0, 4'b0000};
        vecs[2] = '{4'b0110, 1'b1, 1'b0, 4'b0110};
        vecs[3] = '{4'b0000, 1'b1, 1'b1, 4'b1111};
        vecs[4] = '{4'b1010, 1'b0, 1'b1, 4'b1111};
        vecs[5] = '{4'b1100, 1'b1, 1'b0, 4'b1100};
        vecs[6] = '{4'b0011, 1'b1, 1'b0, 4'b0011};

        // Reset state.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        rst_sys_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkAllLow("reset");

        // Boot: strobe spacing, first LOAD timing and the first frame.
        applyStimulus(vecs[0].led_in, vecs[0].led_en, vecs[0].lamp);
        exp_q.push_back(vecs[0].exp_bits);
        rst_sys_n = 1'b1;
        startupCheck("boot");
        waitFrameEnd("boot");

        // Table-driven frames: new inputs applied in the IDLE gap after each frame.
        for (int i = 1; i < NVEC; i++) begin
            applyStimulus(vecs[i].led_in, vecs[i].led_en, vecs[i].lamp);
            exp_q.push_back(vecs[i].exp_bits);
            waitFrameEnd($sformatf("vec%0d", i));
        end

        // Inputs change mid-frame plus a lamp_test edge: frame unchanged, one extra frame follows.
        applyStimulus(4'b1001, 1'b1, 1'b0);
        exp_q.push_back(4'b1001);
        waitBusyRise("midframe");
        waitSclkRises("midframe", 1);
        applyStimulus(4'b0110, 1'b1, 1'b1);
        exp_q.push_back(4'b1111);
        waitFrameEnd("midframe");
        @(negedge clk_sys);
        #1;
        checkOutput("extra_frame_immediate", scan_busy, 1);
        waitFrameEnd("extra");
        applyStimulus(4'b0110, 1'b1, 1'b0);
        exp_q.push_back(4'b0110);
        waitFrameEnd("after_extra");

        // Reset during SHIFT_HI of bit 2: outputs drop at once, frame aborted, counters restart.
        applyStimulus(4'b1111, 1'b1, 1'b0);
        waitBusyRise("abort");
        waitSclkRises("abort", 2);
        #2;
        rst_sys_n = 1'b0;
        #1;
        checkAllLow("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_sys);
            checkOutput($sformatf("abort_no_latch_%0d", i), led_latch, 0);
        end
        applyStimulus(4'b0101, 1'b1, 1'b0);
        exp_q.push_back(4'b0101);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        startupCheck("restart");
        waitFrameEnd("restart");

        // lamp_test rising edge while IDLE: LOAD on the second cycle after the edge.
        rst_sys_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        rst_sys_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            #1;
            if (k == 5) begin
                applyStimulus(4'b0011, 1'b1, 1'b1);
                exp_q.push_back(4'b1111);
            end
            if (k == 6) checkOutput("lamp_idle_busy_k6", scan_busy, 0);
            if (k == 7) checkOutput("lamp_idle_busy_k7", scan_busy, 1);
        end
        waitFrameEnd("lamp_idle");
        applyStimulus(4'b0011, 1'b1, 1'b0);
        exp_q.push_back(4'b0011);
        waitFrameEnd("after_lamp");

        // Stop further frames and make sure every expected frame was seen.
        rst_sys_n = 1'b0;
        @(negedge clk_sys);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
